// File: rtl/cvp14_pkg.sv
// -----------------------------------------------------------------------------
// cvp14_pkg
// Shared definitions for the processor-to-memory interface: the default
// posted-write buffer depth and the interface FSM state encoding.
// -----------------------------------------------------------------------------
package cvp14_pkg;

   // Default number of posted-write buffer entries (power of two, >= 2)
   localparam int DEPTH_DEFAULT = 4;

   // Interface controller states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      DRAIN = 2'b10
   } mem_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// Circular posted-write buffer of {addr, data} entries with an associative
// lookup that returns the data of the newest valid entry matching an address.
//
// Ports
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_push, i_push_addr/data : append an entry at the tail
//   i_pop                    : retire the head entry
//   i_lkp_addr               : address for the newest-match lookup
//   o_full, o_empty          : occupancy flags
//   o_head_addr/data         : oldest entry
//   o_hit, o_hit_data        : lookup result (combinational)
// -----------------------------------------------------------------------------
module wbuf_fifo
   import cvp14_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_push,
   input  logic [15:0] i_push_addr,
   input  logic [15:0] i_push_data,
   input  logic        i_pop,
   input  logic [15:0] i_lkp_addr,
   output logic        o_full,
   output logic        o_empty,
   output logic [15:0] o_head_addr,
   output logic [15:0] o_head_data,
   output logic        o_hit,
   output logic [15:0] o_hit_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [15:0]   r_addr [DEPTH];
   logic [15:0]   r_data [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;

   // Entry storage: written at the tail on every accepted push
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_push) begin
         r_addr[r_tail] <= i_push_addr;
         r_data[r_tail] <= i_push_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (i_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full      = (r_count == CW'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];

   // Newest-match lookup: scan oldest to newest so the last hit overrides
   always_comb begin
      o_hit      = 1'b0;
      o_hit_data = 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         logic          match;
         idx        = r_head + PW'(i);
         match      = (CW'(i) < r_count) && (r_addr[idx] == i_lkp_addr);
         o_hit      = match ? 1'b1 : o_hit;
         o_hit_data = match ? r_data[idx] : o_hit_data;
      end
   end

endmodule

// File: rtl/sys_mem_if.sv
// -----------------------------------------------------------------------------
// sys_mem_if
// Processor-side memory interface with a posted-write buffer. Writes are
// queued and drained to the backing memory in the background; reads are
// served from the buffer on an address hit, otherwise from memory.
//
// Ports
//   Clk1, Reset_n         : clock, synchronous active-low reset
//   Addr, RD, WR, DataOut : processor request
//   DataIn, RdValid       : read response (RdValid is a one-cycle pulse)
//   WrBusy, RdBusy        : write / read rejected this cycle
//   Err                   : sticky protocol error
//   mem_*                 : backing-memory request/response
// -----------------------------------------------------------------------------
module sys_mem_if
   import cvp14_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        Clk1,
   input  logic        Reset_n,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] DataOut,
   output logic [15:0] DataIn,
   output logic        RdValid,
   output logic        WrBusy,
   output logic        RdBusy,
   output logic        Err,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready
);

   mem_state_t  r_state,     w_state_nxt;
   logic [15:0] r_data_in,   w_data_in_nxt;
   logic        r_rd_valid,  w_rd_valid_nxt;
   logic        r_err,       w_err_nxt;
   logic [15:0] r_mem_addr,  w_mem_addr_nxt;
   logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
   logic        r_mem_rd,    w_mem_rd_nxt;
   logic        r_mem_wr,    w_mem_wr_nxt;

   logic        w_full, w_empty, w_hit, w_pop, w_wr_acc, w_rd_acc;
   logic [15:0] w_head_addr, w_head_data, w_hit_data;

   // The head retires on the edge its memory write completes; a full buffer
   // can therefore still take a push in that same cycle.
   assign w_pop    = (r_state == DRAIN) && mem_ready;
   assign w_wr_acc = WR && (!w_full || w_pop);
   assign w_rd_acc = RD && !WR && (r_state == IDLE);

   wbuf_fifo #(.DEPTH(DEPTH)) u_wbuf (
      .i_clk       (Clk1),
      .i_rst_n     (Reset_n),
      .i_push      (w_wr_acc),
      .i_push_addr (Addr),
      .i_push_data (DataOut),
      .i_pop       (w_pop),
      .i_lkp_addr  (Addr),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_hit       (w_hit),
      .o_hit_data  (w_hit_data)
   );

   // Next-state and next-output logic; reads win over a pending drain
   always_comb begin
      w_state_nxt     = r_state;
      w_data_in_nxt   = r_data_in;
      w_rd_valid_nxt  = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_rd_nxt    = r_mem_rd;
      w_mem_wr_nxt    = r_mem_wr;
      w_err_nxt       = r_err
                        | (WR && !w_wr_acc)
                        | (RD && WR)
                        | (RD && (r_state != IDLE));
      case (r_state)
         IDLE: begin
            if (w_rd_acc) begin
               if (w_hit) begin
                  w_data_in_nxt  = w_hit_data;
                  w_rd_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt    = READ;
                  w_mem_rd_nxt   = 1'b1;
                  w_mem_addr_nxt = Addr;
               end
            end else if (!w_empty) begin
               w_state_nxt     = DRAIN;
               w_mem_wr_nxt    = 1'b1;
               w_mem_addr_nxt  = w_head_addr;
               w_mem_wdata_nxt = w_head_data;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         READ: begin
            if (mem_ready) begin
               w_data_in_nxt  = mem_rdata;
               w_rd_valid_nxt = 1'b1;
               w_mem_rd_nxt   = 1'b0;
               w_state_nxt    = IDLE;
            end else begin
               w_state_nxt = READ;
            end
         end
         DRAIN: begin
            if (mem_ready) begin
               w_mem_wr_nxt = 1'b0;
               w_state_nxt  = IDLE;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_mem_rd_nxt = 1'b0;
            w_mem_wr_nxt = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any outstanding request
   always_ff @(posedge Clk1) begin
      if (!Reset_n) begin
         r_state     <= IDLE;
         r_data_in   <= 16'h0000;
         r_rd_valid  <= 1'b0;
         r_err       <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_data_in   <= w_data_in_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_err       <= w_err_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_rd    <= w_mem_rd_nxt;
         r_mem_wr    <= w_mem_wr_nxt;
      end
   end

   assign DataIn    = r_data_in;
   assign RdValid   = r_rd_valid;
   assign Err       = r_err;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign WrBusy    = w_full;
   assign RdBusy    = (r_state != IDLE);

endmodule

// File: tb/tb_sys_mem_if.sv
// -----------------------------------------------------------------------------
// tb_sys_mem_if
// Self-checking bench for sys_mem_if: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-based model.
// Output vector layout everywhere:
//   {DataIn, RdValid, WrBusy, RdBusy, Err, mem_rd, mem_wr, mem_addr, mem_wdata}
// -----------------------------------------------------------------------------
module tb_sys_mem_if;

   localparam int DEPTH = 4;

   logic        Clk1 = 1'b0;
   logic        Reset_n = 1'b0;
   logic [15:0] Addr = 16'h0000;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] DataOut = 16'h0000;
   logic [15:0] DataIn;
   logic        RdValid, WrBusy, RdBusy, Err;
   logic [15:0] mem_addr, mem_wdata;
   logic        mem_rd, mem_wr;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_ready = 1'b0;

   sys_mem_if #(.DEPTH(DEPTH)) dut (
      .Clk1      (Clk1),
      .Reset_n   (Reset_n),
      .Addr      (Addr),
      .RD        (RD),
      .WR        (WR),
      .DataOut   (DataOut),
      .DataIn    (DataIn),
      .RdValid   (RdValid),
      .WrBusy    (WrBusy),
      .RdBusy    (RdBusy),
      .Err       (Err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 Clk1 = ~Clk1;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model (transaction level) ----------------
   typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
   ent_t        q[$];          // posted writes, oldest first
   logic        m_rd_out = 1'b0;   // memory read outstanding
   logic        m_wr_out = 1'b0;   // memory write (of q[0]) outstanding
   logic [15:0] e_din = 16'h0000, e_maddr = 16'h0000, e_mwd = 16'h0000;
   logic        e_valid = 1'b0, e_err = 1'b0;

   task automatic model_step(input logic rst_n, input logic rd, input logic wr,
                             input logic [15:0] a, input logic [15:0] d,
                             input logic rdy, input logic [15:0] rdat);
      logic busy, full, popping, wacc, hit;
      logic [15:0] hd;
      if (!rst_n) begin
         q.delete();
         m_rd_out = 1'b0; m_wr_out = 1'b0;
         e_din = 16'h0000; e_valid = 1'b0; e_err = 1'b0;
         e_maddr = 16'h0000; e_mwd = 16'h0000;
         return;
      end
      busy    = m_rd_out | m_wr_out;
      full    = (q.size() == DEPTH);
      popping = m_wr_out && rdy;
      wacc    = wr && (!full || popping);
      e_valid = 1'b0;
      if ((wr && !wacc) || (rd && (wr || busy))) e_err = 1'b1;
      if (m_rd_out && rdy) begin
         e_din = rdat; e_valid = 1'b1; m_rd_out = 1'b0;
      end
      if (popping) begin
         void'(q.pop_front());
         m_wr_out = 1'b0;
      end
      if (!busy) begin
         if (rd && !wr) begin
            hit = 1'b0; hd = 16'h0000;
            foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; hd = q[i].d; end
            if (hit) begin
               e_din = hd; e_valid = 1'b1;
            end else begin
               m_rd_out = 1'b1; e_maddr = a;
            end
         end else if (q.size() > 0) begin
            m_wr_out = 1'b1; e_maddr = q[0].a; e_mwd = q[0].d;
         end
      end
      if (wacc) q.push_back({a, d});
   endtask

   function automatic logic [53:0] model_vec();
      return {e_din, e_valid, (q.size() == DEPTH), (m_rd_out | m_wr_out), e_err,
              m_rd_out, m_wr_out, e_maddr, e_mwd};
   endfunction

   function automatic logic [53:0] act_vec();
      return {DataIn, RdValid, WrBusy, RdBusy, Err, mem_rd, mem_wr, mem_addr, mem_wdata};
   endfunction

   function automatic logic [53:0] pk(input logic [15:0] din, input logic v, input logic wb,
                                      input logic rb, input logic e, input logic mr,
                                      input logic mw, input logic [15:0] ma,
                                      input logic [15:0] md);
      return {din, v, wb, rb, e, mr, mw, ma, md};
   endfunction

   task automatic chk(input string name, input logic [53:0] act, input logic [53:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, step the model on the edge, compare against it
   task automatic cyc(input logic rst, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic rdy, input logic [15:0] rdat);
      Reset_n = rst; RD = rd; WR = wr; Addr = a; DataOut = d;
      mem_ready = rdy; mem_rdata = rdat;
      @(posedge Clk1);
      model_step(rst, rd, wr, a, d, rdy, rdat);
      #1;
      chk("model", act_vec(), model_vec());
   endtask

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rd, wr;
      logic [15:0] a, d;
      logic        rdy;
      logic [53:0] exp;
   } vec_t;
   vec_t tbl[15];

   logic [15:0] mem_arr [logic [15:0]];
   logic [15:0] got[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Buffer hit, newest-wins, drain addresses/data, RD+WR collision
      tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, pk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000)};
      tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, pk(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000)};
      tbl[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, pk(16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF)};
      tbl[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, pk(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF)};
      tbl[4]  = '{1'b0, 1'b1, 16'h0030, 16'h3333, 1'b0, pk(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'hBEEF)};
      tbl[5]  = '{1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, pk(16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h3333)};
      tbl[6]  = '{1'b0, 1'b1, 16'h0020, 16'h2222, 1'b1, pk(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h3333)};
      tbl[7]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, pk(16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h3333)};
      tbl[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, pk(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111)};
      tbl[9]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, pk(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h1111)};
      tbl[10] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, pk(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h2222)};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, pk(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h2222)};
      tbl[12] = '{1'b1, 1'b1, 16'h0050, 16'h5555, 1'b0, pk(16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h2222)};
      tbl[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, pk(16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h5555)};
      tbl[14] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, pk(16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 16'h5555)};

      repeat (2) @(posedge Clk1);
      #1;
      do_reset();
      chk("reset_state", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));

      for (int i = 0; i < 15; i++) begin
         cyc(1'b1, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].rdy, 16'h0000);
         chk($sformatf("vec%0d", i), act_vec(), tbl[i].exp);
      end

      // Read miss: memory answers on the third mem_rd cycle
      do_reset();
      cyc(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000);
      chk("miss_c1", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("miss_c2", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("miss_c3", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A);
      chk("miss_resp", act_vec(), pk(16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("miss_hold", act_vec(), pk(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000));

      // Overflow: five writes with memory stalled, then drain order
      do_reset();
      for (int i = 1; i <= 4; i++)
         cyc(1'b1, 1'b0, 1'b1, 16'(i), 16'hA000 + 16'(i), 1'b0, 16'h0000);
      chk("full_flag", act_vec(), pk(16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hA001));
      cyc(1'b1, 1'b0, 1'b1, 16'h0005, 16'hA005, 1'b0, 16'h0000);
      chk("full_drop", act_vec(), pk(16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'hA001));
      got.delete();
      for (int c = 0; c < 20; c++) begin
         if (mem_wr) got.push_back(mem_wdata);
         cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
      end
      n_checks++;
      if (got.size() != 4) begin
         n_errors++;
         $display("FAIL drain_count: got %0d expected 4", got.size());
      end
      for (int i = 0; i < got.size() && i < 4; i++)
         chk($sformatf("drain_order%0d", i), {38'd0, got[i]}, {38'd0, 16'hA001 + 16'(i)});

      // Reset while draining with two entries queued; late mem_ready ignored
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, 16'h0100, 16'hC001, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 1'b1, 16'h0101, 16'hC002, 1'b0, 16'h0000);
      chk("pre_reset", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'hC001));
      cyc(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("in_reset", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
      chk("late_ready", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));
      cyc(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("fifo_empty", act_vec(), pk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000));

      // Randomized traffic against a simple backing memory
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic        r_rst, r_rd, r_wr, r_rdy;
         logic [15:0] r_a, r_d, r_rdat;
         r_rst  = ($urandom_range(0, 299) != 0);
         r_rd   = ($urandom_range(0, 99) < 30);
         r_wr   = ($urandom_range(0, 99) < 35);
         r_a    = 16'h0200 + 16'($urandom_range(0, 7));
         r_d    = 16'($urandom);
         r_rdy  = ($urandom_range(0, 1) == 1);
         r_rdat = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : (mem_addr ^ 16'hA5A5);
         if (r_rst && mem_wr && r_rdy) mem_arr[mem_addr] = mem_wdata;
         cyc(r_rst, r_rd, r_wr, r_a, r_d, r_rdy, r_rdat);
         n_checks++;
         if (mem_rd && mem_wr) begin
            n_errors++;
            $display("FAIL rd_wr_exclusive: got both high expected at most one");
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
